corr_ram_ctrl: RTL and testbench

- Sequencer for one correlator coefficient RAM of depth MEMORY_DEPTH = NUM_PARALLEL*NUM_CORRS words.
- Two jobs: load a coefficient set from the host stream into the RAM (write port), then sweep the RAM read port continuously to feed the correlator lanes.
- Sits between the config/host stream and the RAM instance; owns both RAM address busses and the RAM enable.

---
 rtl/corr_ram_ctrl.sv | 160 ++++++++++++++++
 tb/tb_corr_ram_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/corr_ram_ctrl.sv
// Coefficient RAM sequencer: loads a coefficient set from the host stream,
// then sweeps the read port continuously to feed the correlator lanes.
module corr_ram_ctrl #(
  parameter  int NUM_PARALLEL = 8,
  parameter  int DATA_WIDTH   = 12,
  parameter  int NUM_CORRS    = 1,
  localparam int DM           = NUM_PARALLEL * NUM_CORRS - 1,
  localparam int AW           = $clog2(DM + 1),
  localparam int LW           = $clog2(NUM_PARALLEL),
  localparam int CW           = (NUM_CORRS > 1) ? $clog2(NUM_CORRS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  output logic                  ld_done,
  input  logic                  run_start,
  input  logic                  run_stop,
  output logic                  busy,
  output logic                  ram_ena,
  output logic [AW-1:0]         ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic [AW-1:0]         ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [LW-1:0]         out_lane,
  output logic [CW-1:0]         out_corr,
  output logic                  out_last
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_t;

  localparam logic [AW-1:0] DM_A = AW'(DM);

  state_t                r_state;
  state_t                w_state_next;
  logic [AW-1:0]         r_wr_cnt, w_wr_next;
  logic [AW-1:0]         r_rd_cnt, w_rd_next;
  logic                  r_stop_pend, w_stop_next;
  logic                  r_ld_done, w_ld_done_next;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [AW-1:0]         r_out_addr;
  logic                  w_stop_eff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_stop_pend <= 1'b0;
      r_ld_done   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_wr_cnt    <= w_wr_next;
      r_rd_cnt    <= w_rd_next;
      r_stop_pend <= w_stop_next;
      r_ld_done   <= w_ld_done_next;
    end
  end

  assign w_stop_eff = r_stop_pend | run_stop;

  // With ena low every *_next defaults to the current value, freezing the block.
  always_comb begin
    w_state_next   = r_state;
    w_wr_next      = r_wr_cnt;
    w_rd_next      = r_rd_cnt;
    w_stop_next    = r_stop_pend;
    w_ld_done_next = r_ld_done;
    if (ena) begin
      w_ld_done_next = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ld_start) begin
            w_state_next = S_LOAD;
            w_wr_next    = '0;
          end else if (run_start) begin
            w_state_next = S_RUN;
            w_rd_next    = '0;
            w_stop_next  = 1'b0;
          end
        end
        S_LOAD: begin
          if (ld_valid) begin
            if (r_wr_cnt == DM_A) begin
              w_wr_next      = '0;
              w_state_next   = S_IDLE;
              w_ld_done_next = 1'b1;
            end else begin
              w_wr_next = r_wr_cnt + AW'(1);
            end
          end
        end
        S_RUN: begin
          if (r_rd_cnt == DM_A) begin
            w_rd_next = '0;
            if (w_stop_eff) begin
              w_state_next = S_DRAIN;
            end else begin
              w_stop_next = r_stop_pend;
            end
          end else begin
            w_rd_next   = r_rd_cnt + AW'(1);
            w_stop_next = w_stop_eff;
          end
        end
        S_DRAIN: begin
          w_state_next = S_IDLE;
          w_rd_next    = '0;
          w_stop_next  = 1'b0;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Read data is captured one cycle after its address; a masked word is re-presented later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
    end else if (ena) begin
      r_out_valid <= (r_state == S_RUN);
      if (r_state == S_RUN) begin
        r_out_data <= ram_dout;
        r_out_addr <= r_rd_cnt;
        r_out_last <= (r_rd_cnt == DM_A);
      end
    end
  end

  assign ld_ready    = ena & (r_state == S_LOAD);
  assign ram_ena     = ld_ready & ld_valid;
  assign ram_wr_addr = r_wr_cnt;
  assign ram_din     = (r_state == S_LOAD) ? ld_data : '0;
  assign ram_rd_addr = r_rd_cnt;
  assign ld_done     = r_ld_done & ena;
  assign busy        = (r_state != S_IDLE);
  assign out_valid   = r_out_valid & ena;
  assign out_data    = r_out_data;
  assign out_last    = r_out_last & out_valid;
  assign out_lane    = r_out_addr[LW-1:0];

  generate
    if (NUM_CORRS == 1) begin : g_single_corr
      assign out_corr = '0;
    end else begin : g_multi_corr
      assign out_corr = r_out_addr[AW-1:LW];
    end
  endgenerate

endmodule

// File: tb/tb_corr_ram_ctrl.sv
// Bench for corr_ram_ctrl with NUM_PARALLEL=8, NUM_CORRS=2 (16-word RAM).
module tb_corr_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst, ena, ld_start, ld_valid, run_start, run_stop;
  logic [11:0] ld_data, ram_din, ram_dout, out_data;
  logic        ld_ready, ld_done, busy, ram_ena, out_valid, out_last;
  logic [3:0]  ram_wr_addr, ram_rd_addr;
  logic [2:0]  out_lane;
  logic [0:0]  out_corr;

  int checks = 0;
  int errors = 0;

  logic [11:0] ram [16];
  logic [11:0] ref_mem [16];

  always #5 clk = ~clk;

  corr_ram_ctrl #(.NUM_PARALLEL(8), .DATA_WIDTH(12), .NUM_CORRS(2)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_done(ld_done),
    .run_start(run_start), .run_stop(run_stop), .busy(busy),
    .ram_ena(ram_ena), .ram_wr_addr(ram_wr_addr), .ram_din(ram_din),
    .ram_rd_addr(ram_rd_addr), .ram_dout(ram_dout),
    .out_valid(out_valid), .out_data(out_data), .out_lane(out_lane),
    .out_corr(out_corr), .out_last(out_last)
  );

  // RAM with combinational read, as the controller expects
  always @(posedge clk) if (ram_ena) ram[ram_wr_addr] <= ram_din;
  assign ram_dout = ram[ram_rd_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard state for the output bus: next expected address and word count
  int exp_ptr, nwords, last_ptr;

  task automatic obs();
    if (out_valid === 1'b1) begin
      chk("out_data", out_data, ref_mem[exp_ptr]);
      chk("out_lane", out_lane, exp_ptr % 8);
      chk("out_corr", out_corr, exp_ptr / 8);
      chk("out_last", out_last, exp_ptr == 15);
      $display("OUT  word %0d addr %0d data %03h last %0b", nwords, exp_ptr, out_data, out_last);
      last_ptr = exp_ptr;
      exp_ptr  = (exp_ptr + 1) % 16;
      nwords++;
    end
  endtask

  // Load n words; rnd adds random stalls, ena drops and random data.
  task automatic load_words(input int n, input bit rnd);
    int acc = 0;
    int guard = 0;
    ena = 1'b1; ld_start = 1'b1; ld_valid = 1'b0;
    cyc();
    ld_start = 1'b0;
    while (acc < n && guard < 500) begin
      ena      = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
      ld_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ld_data  = rnd ? 12'($urandom) : 12'(256 + acc);
      #1;
      chk("ld_ready", ld_ready, ena);
      chk("ram_ena", ram_ena, ena & ld_valid);
      if (ena && ld_valid) begin
        chk("ram_wr_addr", ram_wr_addr, acc);
        chk("ram_din", ram_din, ld_data);
        $display("LOAD addr %0d data %03h", acc, ld_data);
        ref_mem[acc] = ld_data;
        acc++;
      end
      cyc();
      guard++;
    end
    chk("load_words_accepted", acc, n);
    ld_valid = 1'b0; ena = 1'b1;
    #1;
    if (n == 16) begin
      chk("ld_done_pulse", ld_done, 1);
      chk("busy_after_load", busy, 0);
      chk("ld_ready_after_load", ld_ready, 0);
      cyc();
      chk("ld_done_one_cycle", ld_done, 0);
    end
  endtask

  // ena_mode: 0 always on, 1 three-cycle gap, 2 random. Stop issued at read
  // address stop_at once at least stop_after words have been seen.
  task automatic run_sweep(input int stop_at, input int stop_after, input int ena_mode);
    bit stopped = 0;
    bit done = 0;
    bit prev_ena = 1;
    logic [3:0] prev_addr = 0;
    int exp_total = 0;
    int i = 0;
    exp_ptr = 0; nwords = 0; last_ptr = -1;
    ena = 1'b1; run_start = 1'b1; run_stop = 1'b0;
    cyc();
    run_start = 1'b0;
    while (!done && i < 400) begin
      run_stop = 1'b0;
      if (i < 2) ena = 1'b1;
      else if (ena_mode == 1) ena = !(i >= 10 && i < 13);
      else if (ena_mode == 2) ena = ($urandom_range(0, 3) != 0);
      else ena = 1'b1;
      #1;
      if (i == 0) begin
        chk("run_first_rd_addr", ram_rd_addr, 0);
        chk("run_first_no_valid", out_valid, 0);
      end
      if (i == 1) chk("run_second_valid", out_valid, 1);
      if (!ena) begin
        chk("ena_low_out_valid", out_valid, 0);
        chk("ena_low_ram_ena", ram_ena, 0);
      end
      if (!prev_ena) chk("ena_low_rd_frozen", ram_rd_addr, prev_addr);
      obs();
      if (stopped && ena && !busy) begin
        done = 1;
        chk("stop_idle_out_valid", out_valid, 0);
      end else if (!stopped && ena && nwords >= stop_after && ram_rd_addr == 4'(stop_at)) begin
        run_stop  = 1'b1;
        stopped   = 1;
        exp_total = nwords + (16 - stop_at);
      end
      prev_ena  = ena;
      prev_addr = ram_rd_addr;
      cyc();
      i++;
    end
    run_stop = 1'b0; ena = 1'b1;
    chk("run_terminated", done, 1);
    chk("last_word_addr", last_ptr, 15);
    chk("word_count", nwords, exp_total);
    $display("RUN  stop_at %0d words %0d expected %0d", stop_at, nwords, exp_total);
  endtask

  typedef struct {
    bit          st;
    bit          vld;
    logic [11:0] d;
    bit          e_rdy;
    bit          e_ena;
    logic [3:0]  e_addr;
    bit          e_done;
    bit          e_busy;
  } vec_t;

  vec_t vt [34];

  initial begin
    bit done_seen;
    for (int k = 0; k < 16; k++) begin
      ram[k] = '0;
      ref_mem[k] = '0;
    end
    // Stalled load table: valid toggles 1,0,...; ld_done follows the 16th accept
    vt[0] = '{1'b1, 1'b0, 12'h0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
    for (int k = 0; k < 16; k++) begin
      vt[1 + 2*k] = '{1'b0, 1'b1, 12'(256 + k), 1'b1, 1'b1, 4'(k), 1'b0, 1'b1};
      if (k < 15) vt[2 + 2*k] = '{1'b0, 1'b0, 12'h0, 1'b1, 1'b0, 4'(k + 1), 1'b0, 1'b1};
      else        vt[2 + 2*k] = '{1'b0, 1'b0, 12'h0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0};
    end
    vt[33] = '{1'b0, 1'b0, 12'h0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};

    rst = 1'b1; ena = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
    run_start = 1'b0; run_stop = 1'b0;
    cyc(); cyc();
    chk("rst_busy", busy, 0);
    chk("rst_ld_done", ld_done, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_lane", out_lane, 0);
    chk("rst_wr_addr", ram_wr_addr, 0);
    chk("rst_rd_addr", ram_rd_addr, 0);
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 34; i++) begin
      ena = 1'b1; ld_start = vt[i].st; ld_valid = vt[i].vld; ld_data = vt[i].d;
      #1;
      chk("tbl_ld_ready", ld_ready, vt[i].e_rdy);
      chk("tbl_ram_ena", ram_ena, vt[i].e_ena);
      chk("tbl_wr_addr", ram_wr_addr, vt[i].e_addr);
      chk("tbl_ram_din", ram_din, vt[i].d);
      chk("tbl_ld_done", ld_done, vt[i].e_done);
      chk("tbl_busy", busy, vt[i].e_busy);
      if (vt[i].e_ena) ref_mem[vt[i].e_addr] = vt[i].d;
      $display("VEC  %0d valid %0b addr %0d ena %0b done %0b", i, vt[i].vld, ram_wr_addr, ram_ena, ld_done);
      cyc();
    end
    ld_start = 1'b0; ld_valid = 1'b0;

    run_sweep(5, 16, 0);    // full sweep, stop at address 5 of the second sweep
    cyc();
    run_sweep(15, 3, 1);    // stop exactly at DM, with a three-cycle ena gap
    cyc();

    // ld_start and run_start together in IDLE: load wins
    ld_start = 1'b1; run_start = 1'b1; ena = 1'b1;
    cyc();
    ld_start = 1'b0; run_start = 1'b0;
    #1;
    chk("collision_load", ld_ready, 1);
    chk("collision_no_out", out_valid, 0);
    load_words(16, 0);
    cyc();

    // Asynchronous reset mid-load after 5 words
    load_words(5, 0);
    ld_valid = 1'b1; ld_data = 12'h5AA;
    #1;
    chk("pre_rst_ram_ena", ram_ena, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_ram_ena", ram_ena, 0);
    chk("async_rst_ld_ready", ld_ready, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_wr_addr", ram_wr_addr, 0);
    chk("async_rst_ram_din", ram_din, 0);
    chk("async_rst_out_valid", out_valid, 0);
    cyc();
    rst = 1'b0; ld_valid = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (ld_done) done_seen = 1;
    end
    chk("no_ld_done_after_rst", done_seen, 0);
    load_words(16, 0);
    cyc();

    // Randomised loads and sweeps
    for (int r = 0; r < 4; r++) begin
      load_words(16, 1);
      cyc();
      run_sweep($urandom_range(0, 15), $urandom_range(0, 20), 2);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
